// File: rtl/status_uart_tx_if.sv
// rtl/status_uart_tx_if.sv - frame request and UART line bundle for status_uart_tx
interface status_uart_tx_if;
  logic        send;
  logic [31:0] status;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (output send, output status, input tx, input busy, input done);
  modport slave  (input send, input status, output tx, output busy, output done);
endinterface

// File: rtl/status_uart_tx.sv
// rtl/status_uart_tx.sv - 8N1 transmitter for a 6-byte game status frame
// Frame: sync, status[31:24], [23:16], [15:8], [7:0], XOR of the four status bytes.
module status_uart_tx #(
  parameter int         CLKS_PER_BIT = 10417,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic            clk,
  input  logic            reset,
  status_uart_tx_if.slave bus
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [2:0]  byte_q, byte_d;
  logic [31:0] hold_q, hold_d;
  logic        tx_q, tx_d;
  logic        done_q, done_d;

  logic [7:0]  checksum;
  logic [7:0]  cur_byte;
  logic        baud_end;

  always_comb begin
    checksum = hold_q[31:24] ^ hold_q[23:16] ^ hold_q[15:8] ^ hold_q[7:0];
    case (byte_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = hold_q[31:24];
      3'd2:    cur_byte = hold_q[23:16];
      3'd3:    cur_byte = hold_q[15:8];
      3'd4:    cur_byte = hold_q[7:0];
      default: cur_byte = checksum;
    endcase
    baud_end = (baud_q == BAUD_LAST);
  end

  // tx_d is the level the line takes on in the bit that begins next cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    hold_d  = hold_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.send) begin
          state_d = START;
          hold_d  = bus.status;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          byte_d  = 3'd0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
          tx_d    = cur_byte[0];
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = cur_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = 16'd0;
          bit_d  = 3'd0;
          if (byte_q == LAST_BYTE) begin
            state_d = IDLE;
            byte_d  = 3'd0;
            done_d  = 1'b1;
            tx_d    = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_q + 3'd1;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      byte_q  <= 3'd0;
      hold_q  <= 32'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      hold_q  <= hold_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.done = done_q;

endmodule

// File: tb/tb_status_uart_tx.sv
// tb/tb_status_uart_tx.sv - frame-timing model plus directed frame checks for status_uart_tx
module tb_status_uart_tx;

  localparam int         C    = 4;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int         FLEN = 60 * C;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  bit   chk_en = 1'b0;

  status_uart_tx_if bus_if ();

  status_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(SYNC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a frame is a 240-cycle window; each cycle's line level follows from its offset.
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  int         m_t = 0;
  logic [7:0] m_bytes [6];

  always @(posedge clk) begin
    if (reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else if (!m_active && bus_if.send) begin
      m_active   <= 1'b1;
      m_done     <= 1'b0;
      m_t        <= 0;
      m_bytes[0] <= SYNC;
      m_bytes[1] <= bus_if.status[31:24];
      m_bytes[2] <= bus_if.status[23:16];
      m_bytes[3] <= bus_if.status[15:8];
      m_bytes[4] <= bus_if.status[7:0];
      m_bytes[5] <= bus_if.status[31:24] ^ bus_if.status[23:16]
                  ^ bus_if.status[15:8] ^ bus_if.status[7:0];
    end else if (m_active) begin
      if (m_t == FLEN - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_t    <= m_t + 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  function automatic logic model_tx(input int t);
    int bitn = t / C;
    int b    = bitn / 10;
    int j    = bitn % 10;
    if (j == 0) return 1'b0;
    if (j == 9) return 1'b1;
    return m_bytes[b][j-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus_if.done === 1'b1) done_cnt <= done_cnt + 1;
    if (chk_en) begin
      chk("model_tx",   {31'd0, bus_if.tx},   {31'd0, m_active ? model_tx(m_t) : 1'b1});
      chk("model_busy", {31'd0, bus_if.busy}, {31'd0, m_active});
      chk("model_done", {31'd0, bus_if.done}, {31'd0, m_done});
    end
  end

  task automatic at_cyc(input int n);
    do @(negedge clk); while (cyc < n);
    chk("at_cyc_alignment", cyc, n);
  endtask

  task automatic send_pulse(input bit hold, output int f0);
    bus_if.send = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus_if.send = 1'b0;
    f0 = cyc;
  endtask

  logic [7:0] exp_frame [6];

  task automatic decode(input int f0, input string tag);
    for (int b = 0; b < 6; b++) begin
      logic [7:0] d = 8'h00;
      for (int j = 0; j < 10; j++) begin
        at_cyc(f0 + (10 * b + j) * C + C / 2);
        if (j == 0)      chk($sformatf("%s_start%0d", tag, b), {31'd0, bus_if.tx}, 32'd0);
        else if (j == 9) chk($sformatf("%s_stop%0d", tag, b), {31'd0, bus_if.tx}, 32'd1);
        else             d[j-1] = bus_if.tx;
      end
      chk($sformatf("%s_byte%0d", tag, b), {24'd0, d}, {24'd0, exp_frame[b]});
    end
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation did not finish at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int dc;
    bus_if.send   = 1'b0;
    bus_if.status = 32'h0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    chk("reset_tx", {31'd0, bus_if.tx}, 32'd1);
    repeat (100) @(posedge clk);
    #1;
    chk("idle_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("idle_done_cnt", done_cnt, 0);

    // Single frame with literal timing pins
    exp_frame = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    bus_if.status = 32'h12345678;
    send_pulse(1'b0, f0);
    dc = done_cnt;
    fork
      decode(f0, "single");
      begin
        at_cyc(f0);
        chk("first_start_tx", {31'd0, bus_if.tx}, 32'd0);
        chk("first_busy", {31'd0, bus_if.busy}, 32'd1);
        at_cyc(f0 + C - 1);
        chk("start_still_low", {31'd0, bus_if.tx}, 32'd0);
        at_cyc(f0 + C);
        chk("bit0_a5_high", {31'd0, bus_if.tx}, 32'd1);
        at_cyc(f0 + FLEN - 1);
        chk("last_busy", {31'd0, bus_if.busy}, 32'd1);
        at_cyc(f0 + FLEN);
        chk("end_busy", {31'd0, bus_if.busy}, 32'd0);
        chk("end_done", {31'd0, bus_if.done}, 32'd1);
        chk("end_tx", {31'd0, bus_if.tx}, 32'd1);
        at_cyc(f0 + FLEN + 1);
        chk("done_one_cycle", {31'd0, bus_if.done}, 32'd0);
      end
    join
    chk("single_done_cnt", done_cnt - dc, 1);

    // Latched status and ignored send
    bus_if.status = 32'h12345678;
    send_pulse(1'b0, f0);
    dc = done_cnt;
    fork
      decode(f0, "latch");
      begin
        at_cyc(f0 + 19);
        bus_if.status = 32'hFFFFFFFF;
        at_cyc(f0 + 49);
        bus_if.send = 1'b1;
        at_cyc(f0 + 50);
        bus_if.send = 1'b0;
      end
    join
    at_cyc(f0 + FLEN + 20);
    chk("latch_tx_idle", {31'd0, bus_if.tx}, 32'd1);
    chk("latch_done_cnt", done_cnt - dc, 1);

    // Back-to-back frames with send held high
    exp_frame = '{8'hA5, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
    bus_if.status = 32'h00FF00FF;
    send_pulse(1'b1, f0);
    decode(f0, "b2b0");
    at_cyc(f0 + FLEN);
    chk("b2b_done", {31'd0, bus_if.done}, 32'd1);
    at_cyc(f0 + FLEN + 1);
    chk("b2b_restart_tx", {31'd0, bus_if.tx}, 32'd0);
    chk("b2b_restart_busy", {31'd0, bus_if.busy}, 32'd1);
    bus_if.send = 1'b0;
    decode(f0 + FLEN + 1, "b2b1");
    at_cyc(f0 + 2 * FLEN + 1);
    chk("b2b_second_done", {31'd0, bus_if.done}, 32'd1);
    at_cyc(f0 + 2 * FLEN + 10);
    chk("b2b_no_third", {31'd0, bus_if.busy}, 32'd0);

    // Reset mid-frame, then a clean frame
    exp_frame = '{8'hA5, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    bus_if.status = 32'h12345678;
    send_pulse(1'b0, f0);
    dc = done_cnt;
    at_cyc(f0 + 99);
    reset = 1'b1;
    bus_if.send = 1'b1;
    at_cyc(f0 + 100);
    chk("rst_tx", {31'd0, bus_if.tx}, 32'd1);
    chk("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    chk("rst_done", {31'd0, bus_if.done}, 32'd0);
    reset = 1'b0;
    bus_if.send = 1'b0;
    at_cyc(f0 + FLEN + 20);
    chk("rst_no_done", done_cnt - dc, 0);
    send_pulse(1'b0, f0);
    decode(f0, "after_rst");
    at_cyc(f0 + FLEN + 2);
    chk("after_rst_done_cnt", done_cnt - dc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
